// File: rtl/comparator_event_filter.sv
// comparator_event_filter
//   Digital back end for the analog comparator. Sequences the comparator EN
//   pin, waits out the analog settling window, synchronises and debounces the
//   asynchronous comparator output, and raises a sticky interrupt on selected
//   filtered edges.
// Ports:
//   clk       system clock
//   resetn    asynchronous active-low reset
//   enable    software enable for the comparator channel
//   filt_len  debounce length in clocks (0 behaves as 1)
//   irq_mode  00 none, 01 rising, 10 falling, 11 both edges
//   irq_clr   single-cycle clear of the sticky irq
//   cmp_en    comparator EN pin (registered)
//   cmp_out   raw comparator output, asynchronous to clk
//   level     filtered comparator level (registered)
//   valid     level is meaningful (registered)
//   irq       sticky interrupt request (registered)
module comparator_event_filter #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned FILT_W        = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [1:0]        irq_mode,
    input  logic              irq_clr,
    output logic              cmp_en,
    input  logic              cmp_out,
    output logic              level,
    output logic              valid,
    output logic              irq
);

    localparam int unsigned       SETTLE_W    = 16;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [FILT_W-1:0]   FILT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                s1_q, s2_q;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [FILT_W-1:0]   filt_cnt_q, filt_cnt_d;
    logic [FILT_W-1:0]   filt_last;
    logic                cmp_en_q, cmp_en_d;
    logic                level_q, level_d;
    logic                valid_q, valid_d;
    logic                irq_q, irq_d;
    logic                evt_rise, evt_fall;

    // State, synchroniser and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            settle_cnt_q <= '0;
            filt_cnt_q   <= '0;
            cmp_en_q     <= 1'b0;
            level_q      <= 1'b0;
            valid_q      <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= cmp_out;
            s2_q         <= s1_q;
            settle_cnt_q <= settle_cnt_d;
            filt_cnt_q   <= filt_cnt_d;
            cmp_en_q     <= cmp_en_d;
            level_q      <= level_d;
            valid_q      <= valid_d;
            irq_q        <= irq_d;
        end
    end

    // Next-state logic; dropping enable returns to IDLE from anywhere
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_SETTLE;
                ST_SETTLE: if (settle_cnt_q == SETTLE_LAST) state_d = ST_RUN;
                ST_RUN:    state_d = ST_RUN;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs, counters and edge events
    always_comb begin
        cmp_en_d     = cmp_en_q;
        level_d      = level_q;
        valid_d      = valid_q;
        settle_cnt_d = settle_cnt_q;
        filt_cnt_d   = filt_cnt_q;
        evt_rise     = 1'b0;
        evt_fall     = 1'b0;
        // Zero length behaves as one: commit on the first differing cycle
        filt_last    = (filt_len == '0) ? '0 : filt_len - FILT_W'(1);

        if (!enable) begin
            cmp_en_d     = 1'b0;
            level_d      = 1'b0;
            valid_d      = 1'b0;
            settle_cnt_d = '0;
            filt_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmp_en_d     = 1'b1;
                    settle_cnt_d = '0;
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        // Initial load of the level is not an edge event
                        valid_d    = 1'b1;
                        level_d    = s2_q;
                        filt_cnt_d = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                    end
                end
                ST_RUN: begin
                    if (s2_q == level_q) begin
                        filt_cnt_d = '0;
                    end else if (filt_cnt_q >= filt_last) begin
                        // >= so a shortened filt_len commits on the next differing cycle
                        level_d    = s2_q;
                        filt_cnt_d = '0;
                        evt_rise   = s2_q;
                        evt_fall   = !s2_q;
                    end else if (filt_cnt_q != FILT_MAX) begin
                        filt_cnt_d = filt_cnt_q + FILT_W'(1);
                    end
                end
                default: ;
            endcase
        end

        // A qualifying event beats a simultaneous clear
        if ((evt_rise && irq_mode[0]) || (evt_fall && irq_mode[1])) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    assign cmp_en = cmp_en_q;
    assign level  = level_q;
    assign valid  = valid_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_comparator_event_filter.sv
// tb_comparator_event_filter
//   Scenario tasks plus a randomized run, all compared against a behavioural
//   model of settling, debouncing and the sticky interrupt.
module tb_comparator_event_filter;

    localparam int unsigned SETTLE = 16;
    localparam int unsigned FW     = 8;

    logic          clk      = 1'b0;
    logic          resetn   = 1'b0;
    logic          enable   = 1'b0;
    logic [FW-1:0] filt_len = '0;
    logic [1:0]    irq_mode = 2'b00;
    logic          irq_clr  = 1'b0;
    logic          cmp_out  = 1'b0;
    logic          cmp_en, level, valid, irq;

    comparator_event_filter #(
        .SETTLE_CYCLES(SETTLE),
        .FILT_W       (FW)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .enable  (enable),
        .filt_len(filt_len),
        .irq_mode(irq_mode),
        .irq_clr (irq_clr),
        .cmp_en  (cmp_en),
        .cmp_out (cmp_out),
        .level   (level),
        .valid   (valid),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int npass  = 0;
    int ntotal = 0;

    // Model: sync pipe, enabled-cycle age, consecutive-differing run length
    bit m_s1, m_s2, m_level, m_valid, m_cmp_en, m_irq;
    int m_age, m_run;

    logic [3:0] dvec;
    assign dvec = {cmp_en, valid, level, irq};

    function automatic logic [3:0] mvec();
        return {m_cmp_en, m_valid, m_level, m_irq};
    endfunction

    // Advance one clock edge and update the model from pre-edge values
    task automatic tick();
        bit n_level = m_level, n_valid = m_valid, n_cmp_en = m_cmp_en, n_irq = m_irq;
        bit ev = 1'b0;
        int n_age = m_age, n_run = m_run;
        int len = (filt_len == 0) ? 1 : int'(filt_len);
        if (!enable) begin
            n_age = 0; n_run = 0; n_level = 1'b0; n_valid = 1'b0; n_cmp_en = 1'b0;
        end else if (m_valid) begin
            if (m_s2 == m_level) begin
                n_run = 0;
            end else if (m_run + 1 >= len) begin
                n_level = m_s2;
                n_run   = 0;
                ev      = m_s2 ? irq_mode[0] : irq_mode[1];
            end else begin
                n_run = m_run + 1;
            end
        end else begin
            n_age    = m_age + 1;
            n_cmp_en = 1'b1;
            if (n_age == SETTLE + 1) begin
                n_valid = 1'b1;
                n_level = m_s2;
                n_run   = 0;
            end
        end
        if (ev) n_irq = 1'b1;
        else if (irq_clr) n_irq = 1'b0;
        @(posedge clk);
        #1;
        m_s2 = m_s1; m_s1 = cmp_out;
        m_level = n_level; m_valid = n_valid; m_cmp_en = n_cmp_en; m_irq = n_irq;
        m_age = n_age; m_run = n_run;
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable = 1'b1; cmp_out = 1'b1; filt_len = FW'(4); irq_mode = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        ntotal++;
        if (dvec !== 4'b0000) $display("FAIL reset: outputs=%b expected=0000", dvec);
        else npass++;
        m_s1 = 0; m_s2 = 0; m_level = 0; m_valid = 0; m_cmp_en = 0; m_irq = 0;
        m_age = 0; m_run = 0;
        resetn = 1'b1;
    endtask

    task automatic test_settle();
        for (int k = 1; k <= 17; k++) begin
            tick();
            ntotal++;
            if (dvec !== mvec()) $display("FAIL settle_model k=%0d: dut=%b model=%b", k, dvec, mvec());
            else npass++;
            if (k == 1) begin
                ntotal++;
                if (cmp_en !== 1'b1) $display("FAIL settle_cmp_en: cmp_en=%b expected 1", cmp_en);
                else npass++;
            end
            if (k == 16) begin
                ntotal++;
                if (valid !== 1'b0) $display("FAIL settle_early: valid=%b expected 0", valid);
                else npass++;
            end
        end
        ntotal++;
        if ({valid, level, irq} !== 3'b110) $display("FAIL settle_done: v/l/i=%b expected 110", {valid, level, irq});
        else npass++;
    endtask

    task automatic test_latency();
        cmp_out = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            ntotal++;
            if (dvec !== mvec()) $display("FAIL latency_pre k=%0d: dut=%b model=%b", k, dvec, mvec());
            else npass++;
        end
        cmp_out = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) begin
                ntotal++;
                if (level !== 1'b0) $display("FAIL latency_early: level=%b expected 0", level);
                else npass++;
            end
        end
        ntotal++;
        if ({level, irq} !== 2'b11) $display("FAIL latency_commit: level/irq=%b expected 11", {level, irq});
        else npass++;
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        ntotal++;
        if (dvec !== mvec()) $display("FAIL latency_clr: dut=%b model=%b", dvec, mvec());
        else npass++;
    endtask

    task automatic test_glitch();
        bit saw_high = 1'b0;
        cmp_out = 1'b0;
        repeat (8) tick();
        for (int k = 0; k < 12; k++) begin
            cmp_out = (k < 3);
            tick();
            ntotal++;
            if ({level, irq} !== 2'b00) $display("FAIL glitch_short k=%0d: level/irq=%b expected 00", k, {level, irq});
            else npass++;
        end
        for (int k = 0; k < 12; k++) begin
            cmp_out = (k < 5);
            tick();
            if (level === 1'b1) saw_high = 1'b1;
            ntotal++;
            if (dvec !== mvec()) $display("FAIL glitch_long k=%0d: dut=%b model=%b", k, dvec, mvec());
            else npass++;
        end
        ntotal++;
        if ({saw_high, level} !== 2'b10) $display("FAIL glitch_toggle: seen/final=%b expected 10", {saw_high, level});
        else npass++;
    endtask

    task automatic test_irq_clr_race();
        irq_mode = 2'b11;
        cmp_out  = 1'b1;
        repeat (6) tick();
        cmp_out = 1'b0;
        repeat (5) tick();
        irq_clr = 1'b1;
        tick();
        ntotal++;
        if ({level, irq} !== 2'b01) $display("FAIL race_event_wins: level/irq=%b expected 01", {level, irq});
        else npass++;
        tick();
        irq_clr = 1'b0;
        ntotal++;
        if (irq !== 1'b0) $display("FAIL race_clear: irq=%b expected 0", irq);
        else npass++;
    endtask

    task automatic test_disable();
        cmp_out = 1'b1;
        repeat (6) tick();
        cmp_out = 1'b0;
        repeat (4) tick();
        enable = 1'b0;
        tick();
        ntotal++;
        if (dvec !== 4'b0001) $display("FAIL disable: outputs=%b expected 0001", dvec);
        else npass++;
        tick();
        enable = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 16) begin
                ntotal++;
                if (valid !== 1'b0) $display("FAIL resettle_early: valid=%b expected 0", valid);
                else npass++;
            end
        end
        ntotal++;
        if (dvec !== 4'b1101) $display("FAIL resettle_done: outputs=%b expected 1101", dvec);
        else npass++;
    endtask

    task automatic test_fast_follow();
        int falls = 0;
        filt_len = '0;
        irq_mode = 2'b10;
        irq_clr  = 1'b1;
        tick();
        irq_clr = 1'b0;
        for (int j = 0; j < 32; j++) begin
            logic exp_level;
            cmp_out = ((j / 4) % 2) == 1;
            tick();
            irq_clr = 1'b0;
            if (irq === 1'b1) begin
                falls++;
                irq_clr = 1'b1;
            end
            if (j >= 2) begin
                exp_level = (((j - 2) / 4) % 2) == 1;
                ntotal++;
                if (level !== exp_level) $display("FAIL fast_follow j=%0d: level=%b expected %b", j, level, exp_level);
                else npass++;
            end
        end
        irq_clr = 1'b0;
        tick();
        ntotal++;
        if (falls != 3) $display("FAIL fast_falls: count=%0d expected 3", falls);
        else npass++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(3) == 0) cmp_out = ~cmp_out;
            if ($urandom_range(19) == 0) filt_len = FW'($urandom_range(6));
            if ($urandom_range(29) == 0) irq_mode = 2'($urandom_range(3));
            irq_clr = ($urandom_range(7) == 0);
            if (!enable) enable = ($urandom_range(2) == 0);
            else if ($urandom_range(119) == 0) enable = 1'b0;
            tick();
            ntotal++;
            if (dvec !== mvec()) begin
                if (errs < 10) $display("FAIL random k=%0d: dut=%b model=%b", k, dvec, mvec());
                errs++;
            end else begin
                npass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_settle();
        test_latency();
        test_glitch();
        test_irq_clr_race();
        test_disable();
        test_fast_follow();
        test_random();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
